// File: rtl/framebuffer_fetch.sv
// framebuffer_fetch: streams one frame of pixels from word-addressed memory into a
// first-word-fall-through FIFO, issuing bursts only when FIFO space covers them.
module framebuffer_fetch #(
   parameter int unsigned FRAME_PIXELS = 384000,
   parameter int unsigned BURST_LEN    = 16,
   parameter int unsigned FIFO_DEPTH   = 64
) (
   input  logic        in_clk,
   input  logic        in_reset_n,
   input  logic        in_next_frame,
   input  logic [31:0] in_base_addr,
   output logic [31:0] out_mem_address,
   output logic        out_mem_read,
   output logic [4:0]  out_mem_burstcount,
   input  logic        in_mem_waitrequest,
   input  logic [31:0] in_mem_readdata,
   input  logic        in_mem_readdatavalid,
   output logic [23:0] out_pixel_data,
   output logic        out_pixel_valid,
   input  logic        in_pixel_ready,
   output logic        out_underflow,
   output logic        out_busy
);

   localparam int unsigned AW  = $clog2(FIFO_DEPTH);
   localparam int unsigned CW  = AW + 1;
   localparam int unsigned CW1 = CW + 1;
   localparam int unsigned PW  = $clog2(FRAME_PIXELS + 1);

   typedef enum logic [1:0] {StIdle, StFlush, StFetch, StDone} state_e;

   state_e          state_q, state_d;
   logic            nf_q;
   logic [31:0]     addr_q, addr_d;
   logic [PW-1:0]   remaining_q, remaining_d;
   logic [CW-1:0]   outstanding_q, outstanding_d;
   logic            req_q, req_d;
   logic [4:0]      burst_q, burst_d;
   logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]   count_q, count_d;
   logic            underflow_q, underflow_d;
   logic [PW-1:0]   popped_q, popped_d;
   logic [23:0]     mem_q [FIFO_DEPTH];

   logic            start, accept, ret, push, pop, starve, credit_ok;
   logic [PW-1:0]   next_burst;
   logic [CW1-1:0]  free_w, need_w;
   logic            unused_readdata;

   assign unused_readdata = ^in_mem_readdata[31:24];

   assign start  = in_next_frame & ~nf_q;
   assign accept = req_q & ~in_mem_waitrequest;
   // Returns with nothing outstanding are strays (e.g. after reset) and are dropped
   assign ret    = in_mem_readdatavalid & (outstanding_q != '0);
   assign push   = ret & ~start & ((state_q == StFetch) | (state_q == StDone));
   assign pop    = out_pixel_valid & in_pixel_ready;
   assign starve = ((state_q == StFetch) | (state_q == StDone)) & ~in_next_frame &
                   in_pixel_ready & (count_q == '0) & (popped_q < PW'(FRAME_PIXELS));

   assign next_burst = (remaining_q > PW'(BURST_LEN)) ? PW'(BURST_LEN) : remaining_q;
   // Words already in flight count against FIFO space so returns can never overflow it
   assign free_w     = CW1'(FIFO_DEPTH) - {1'b0, count_q};
   assign need_w     = {1'b0, outstanding_q} + CW1'(next_burst);
   assign credit_ok  = free_w >= need_w;

   assign out_mem_address    = addr_q;
   assign out_mem_read       = req_q;
   assign out_mem_burstcount = burst_q;
   assign out_underflow      = underflow_q;
   assign out_busy           = state_q != StIdle;
   assign out_pixel_valid    = (count_q != '0) & ~in_next_frame;
   assign out_pixel_data     = mem_q[rd_ptr_q];

   // Next-state logic: FSM, request channel, credit counters and FIFO pointers
   always_comb begin
      state_d       = state_q;
      addr_d        = addr_q;
      remaining_d   = remaining_q;
      req_d         = req_q;
      burst_d       = burst_q;
      outstanding_d = outstanding_q;
      wr_ptr_d      = wr_ptr_q;
      rd_ptr_d      = rd_ptr_q;
      count_d       = count_q + CW'(push) - CW'(pop);
      popped_d      = popped_q + PW'(pop);
      underflow_d   = underflow_q | starve;

      if (accept) begin
         addr_d        = addr_q + 32'(burst_q);
         remaining_d   = remaining_q - PW'(burst_q);
         outstanding_d = outstanding_d + CW'(burst_q);
         req_d         = 1'b0;
      end
      if (ret) outstanding_d = outstanding_d - CW'(1);
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop) rd_ptr_d = rd_ptr_q + AW'(1);

      case (state_q)
         StFlush: begin
            if (outstanding_q == '0) state_d = StFetch;
         end
         StFetch: begin
            if (!req_q && remaining_q == '0 && outstanding_q == '0) begin
               state_d = StDone;
            end else if (!req_q && remaining_q != '0 && credit_ok) begin
               req_d   = 1'b1;
               burst_d = 5'(next_burst);
            end
         end
         default: ;
      endcase

      // Frame start overrides everything; an unaccepted request is abandoned
      if (start) begin
         addr_d      = in_base_addr;
         remaining_d = PW'(FRAME_PIXELS);
         req_d       = 1'b0;
         wr_ptr_d    = '0;
         rd_ptr_d    = '0;
         count_d     = '0;
         popped_d    = '0;
         underflow_d = 1'b0;
         state_d     = (outstanding_d == '0) ? StFetch : StFlush;
      end
   end

   // State registers with asynchronous active-low reset
   always_ff @(posedge in_clk or negedge in_reset_n) begin
      if (!in_reset_n) begin
         state_q       <= StIdle;
         nf_q          <= 1'b0;
         addr_q        <= '0;
         remaining_q   <= '0;
         outstanding_q <= '0;
         req_q         <= 1'b0;
         burst_q       <= '0;
         wr_ptr_q      <= '0;
         rd_ptr_q      <= '0;
         count_q       <= '0;
         underflow_q   <= 1'b0;
         popped_q      <= '0;
      end else begin
         state_q       <= state_d;
         nf_q          <= in_next_frame;
         addr_q        <= addr_d;
         remaining_q   <= remaining_d;
         outstanding_q <= outstanding_d;
         req_q         <= req_d;
         burst_q       <= burst_d;
         wr_ptr_q      <= wr_ptr_d;
         rd_ptr_q      <= rd_ptr_d;
         count_q       <= count_d;
         underflow_q   <= underflow_d;
         popped_q      <= popped_d;
      end
   end

   // FIFO storage; contents need no reset since the count gates visibility
   always_ff @(posedge in_clk) begin
      if (push) mem_q[wr_ptr_q] <= in_mem_readdata[23:0];
   end

endmodule

// File: tb/tb_framebuffer_fetch.sv
// Scoreboard bench for framebuffer_fetch: stimulus queues expected bursts and pixels,
// a memory model answers requests, and a monitor compares accepted bursts and pops.
module tb_framebuffer_fetch;

   localparam int FP  = 72;
   localparam int BL  = 16;
   localparam int FD  = 64;
   localparam int BIG = 1000000;

   logic        in_clk, in_reset_n, in_next_frame;
   logic [31:0] in_base_addr;
   logic [31:0] out_mem_address;
   logic        out_mem_read;
   logic [4:0]  out_mem_burstcount;
   logic        in_mem_waitrequest;
   logic [31:0] in_mem_readdata;
   logic        in_mem_readdatavalid;
   logic [23:0] out_pixel_data;
   logic        out_pixel_valid, in_pixel_ready, out_underflow, out_busy;

   logic [31:0] ret_q [$];
   logic [31:0] exp_addr [$];
   logic [4:0]  exp_cnt [$];
   logic [23:0] exp_pix [$];
   int          stall_left, ret_budget;
   int          n_vec = 0;
   int          n_err = 0;
   logic        prev_stall;
   logic [31:0] prev_addr;
   logic [4:0]  prev_cnt;

   framebuffer_fetch #(.FRAME_PIXELS(FP), .BURST_LEN(BL), .FIFO_DEPTH(FD)) dut (
      .in_clk               (in_clk),
      .in_reset_n           (in_reset_n),
      .in_next_frame        (in_next_frame),
      .in_base_addr         (in_base_addr),
      .out_mem_address      (out_mem_address),
      .out_mem_read         (out_mem_read),
      .out_mem_burstcount   (out_mem_burstcount),
      .in_mem_waitrequest   (in_mem_waitrequest),
      .in_mem_readdata      (in_mem_readdata),
      .in_mem_readdatavalid (in_mem_readdatavalid),
      .out_pixel_data       (out_pixel_data),
      .out_pixel_valid      (out_pixel_valid),
      .in_pixel_ready       (in_pixel_ready),
      .out_underflow        (out_underflow),
      .out_busy             (out_busy)
   );

   initial begin
      in_clk = 1'b0;
      forever #5 in_clk = ~in_clk;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1);
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [23:0] pix_of(input logic [31:0] a);
      return a[23:0] ^ 24'hA5A5A5;
   endfunction

   // Memory model: returns one word per cycle, optional stall and return budget
   initial begin
      logic [31:0] a;
      in_mem_waitrequest   = 1'b0;
      in_mem_readdatavalid = 1'b0;
      in_mem_readdata      = 32'h0;
      forever begin
         @(negedge in_clk);
         if (ret_q.size() != 0 && ret_budget != 0) begin
            a = ret_q.pop_front();
            in_mem_readdatavalid = 1'b1;
            in_mem_readdata      = {8'hEE, pix_of(a)};
            ret_budget--;
         end else begin
            in_mem_readdatavalid = 1'b0;
            in_mem_readdata      = 32'hDEAD_BEEF;
         end
         if (out_mem_read && in_reset_n) begin
            if (stall_left != 0) begin
               in_mem_waitrequest = 1'b1;
               stall_left--;
            end else begin
               in_mem_waitrequest = 1'b0;
               for (int i = 0; i < int'(out_mem_burstcount); i++)
                  ret_q.push_back(out_mem_address + 32'(i));
            end
         end else begin
            in_mem_waitrequest = 1'b0;
         end
      end
   end

   // Monitor: compares accepted bursts, request stability and popped pixels
   initial begin
      logic [31:0] ea;
      logic [4:0]  ec;
      logic [23:0] ep;
      prev_stall = 1'b0;
      prev_addr  = '0;
      prev_cnt   = '0;
      forever begin
         @(negedge in_clk);
         #1;
         if (!in_reset_n) begin
            prev_stall = 1'b0;
         end else begin
            if (prev_stall && out_mem_read) begin
               check("req_addr_stable", out_mem_address, prev_addr);
               check("req_cnt_stable", out_mem_burstcount, prev_cnt);
            end
            if (out_mem_read && !in_mem_waitrequest) begin
               if (exp_addr.size() == 0) begin
                  n_vec++;
                  n_err++;
                  $display("FAIL unexpected_req: got 0x%0h/%0d, expected none",
                           out_mem_address, out_mem_burstcount);
               end else begin
                  ea = exp_addr.pop_front();
                  ec = exp_cnt.pop_front();
                  check("req_addr", out_mem_address, ea);
                  check("req_cnt", out_mem_burstcount, ec);
               end
            end
            prev_stall = out_mem_read && in_mem_waitrequest;
            prev_addr  = out_mem_address;
            prev_cnt   = out_mem_burstcount;
            if (out_pixel_valid && in_pixel_ready) begin
               if (exp_pix.size() == 0) begin
                  n_vec++;
                  n_err++;
                  $display("FAIL unexpected_pixel: got 0x%0h, expected none", out_pixel_data);
               end else begin
                  ep = exp_pix.pop_front();
                  check("pixel", out_pixel_data, ep);
               end
            end
         end
      end
   end

   task automatic cycles(input int k);
      repeat (k) @(posedge in_clk);
      #1;
   endtask

   // Queue expected bursts (up to nreq) and optionally the whole frame's pixels
   task automatic push_frame(input logic [31:0] base, input int nreq, input bit pix);
      logic [31:0] a;
      int rem;
      int b;
      a   = base;
      rem = FP;
      for (int k = 0; k < nreq && rem > 0; k++) begin
         b = (rem > BL) ? BL : rem;
         exp_addr.push_back(a);
         exp_cnt.push_back(5'(b));
         a   = a + 32'(b);
         rem = rem - b;
      end
      if (pix) for (int i = 0; i < FP; i++) exp_pix.push_back(pix_of(base + 32'(i)));
   endtask

   task automatic frame_start(input logic [31:0] base);
      in_base_addr  = base;
      in_next_frame = 1'b1;
      cycles(1);
   endtask

   task automatic wait_drained(input string name, input int budget);
      int n;
      n = 0;
      while ((exp_addr.size() != 0 || exp_pix.size() != 0) && n < budget) begin
         cycles(1);
         n++;
      end
      check(name, 64'(exp_addr.size() + exp_pix.size()), 64'd0);
      exp_addr.delete();
      exp_cnt.delete();
      exp_pix.delete();
   endtask

   task automatic finish_frame(input string name, input int hold);
      cycles(hold);
      in_next_frame  = 1'b0;
      in_pixel_ready = 1'b1;
      wait_drained(name, 400);
      cycles(4);
      check({name, "_underflow"}, out_underflow, 1'b0);
      check({name, "_read_idle"}, out_mem_read, 1'b0);
   endtask

   initial begin
      int n;
      in_reset_n     = 1'b0;
      in_next_frame  = 1'b0;
      in_base_addr   = 32'h0;
      in_pixel_ready = 1'b0;
      stall_left     = 0;
      ret_budget     = BIG;
      cycles(3);
      check("rst_read", out_mem_read, 1'b0);
      check("rst_addr", out_mem_address, 32'h0);
      check("rst_cnt", out_mem_burstcount, 5'd0);
      check("rst_valid", out_pixel_valid, 1'b0);
      check("rst_underflow", out_underflow, 1'b0);
      check("rst_busy", out_busy, 1'b0);
      in_reset_n = 1'b1;
      cycles(3);
      check("idle_busy", out_busy, 1'b0);
      check("idle_read", out_mem_read, 1'b0);

      // Prefetch while the display is blanking: FIFO fills, pixels held back
      push_frame(32'h0000_1000, 8, 1'b1);
      frame_start(32'h0000_1000);
      for (int i = 0; i < 10; i++) begin
         cycles(10);
         check("hold_valid", out_pixel_valid, 1'b0);
      end
      check("fill_reqs_left", 64'(exp_addr.size()), 64'd1);
      check("fill_read_idle", out_mem_read, 1'b0);
      check("fill_busy", out_busy, 1'b1);
      finish_frame("frame_1000", 0);
      check("done_busy", out_busy, 1'b1);

      // First burst stalled 5 cycles, base chosen so addresses wrap past 2^32
      stall_left = 5;
      push_frame(32'hFFFF_FFE0, 8, 1'b1);
      frame_start(32'hFFFF_FFE0);
      finish_frame("frame_wrap", 30);

      // New frame start with 12 words still in flight
      ret_budget     = 0;
      in_pixel_ready = 1'b0;
      push_frame(32'h0000_3000, 4, 1'b0);
      frame_start(32'h0000_3000);
      n = 0;
      while (ret_q.size() != 64 && n < 100) begin
         cycles(1);
         n++;
      end
      check("flush_inflight", 64'(ret_q.size()), 64'd64);
      check("flush_reqs_done", 64'(exp_addr.size()), 64'd0);
      ret_budget = 52;
      n = 0;
      while (ret_q.size() != 12 && n < 100) begin
         cycles(1);
         n++;
      end
      check("flush_left12", 64'(ret_q.size()), 64'd12);
      in_next_frame = 1'b0;
      cycles(1);
      push_frame(32'h0000_4000, 8, 1'b1);
      frame_start(32'h0000_4000);
      cycles(5);
      check("flush_no_req", out_mem_read, 1'b0);
      check("flush_busy", out_busy, 1'b1);
      ret_budget = BIG;
      finish_frame("frame_4000", 40);

      // Starvation: memory stalled, consumer ready, FIFO empty
      stall_left = BIG;
      frame_start(32'h0000_5000);
      in_next_frame  = 1'b0;
      in_pixel_ready = 1'b1;
      cycles(4);
      check("uf_set", out_underflow, 1'b1);
      check("uf_req_addr", out_mem_address, 32'h0000_5000);
      check("uf_req_cnt", out_mem_burstcount, 5'd16);
      cycles(20);
      check("uf_sticky", out_underflow, 1'b1);
      push_frame(32'h0000_6000, 8, 1'b1);
      frame_start(32'h0000_6000);
      check("uf_cleared", out_underflow, 1'b0);
      stall_left = 0;
      finish_frame("frame_6000", 20);

      // Reset mid-frame with 8 words outstanding, then stray returns
      ret_budget     = 0;
      in_pixel_ready = 1'b0;
      exp_addr.push_back(32'h0000_7000);
      exp_cnt.push_back(5'd16);
      frame_start(32'h0000_7000);
      n = 0;
      while (exp_addr.size() != 0 && n < 50) begin
         cycles(1);
         n++;
      end
      stall_left = BIG;
      check("rst_first_accept", 64'(exp_addr.size()), 64'd0);
      ret_budget = 8;
      n = 0;
      while (ret_q.size() != 8 && n < 50) begin
         cycles(1);
         n++;
      end
      check("rst_left8", 64'(ret_q.size()), 64'd8);
      #2;
      in_reset_n    = 1'b0;
      in_next_frame = 1'b0;
      #1;
      check("mid_rst_read", out_mem_read, 1'b0);
      check("mid_rst_addr", out_mem_address, 32'h0);
      check("mid_rst_cnt", out_mem_burstcount, 5'd0);
      check("mid_rst_valid", out_pixel_valid, 1'b0);
      check("mid_rst_busy", out_busy, 1'b0);
      check("mid_rst_underflow", out_underflow, 1'b0);
      stall_left = 0;
      ret_budget = BIG;
      cycles(3);
      in_reset_n = 1'b1;
      n = 0;
      while (ret_q.size() != 0 && n < 50) begin
         cycles(1);
         n++;
      end
      cycles(3);
      check("stray_idle_busy", out_busy, 1'b0);
      check("stray_idle_read", out_mem_read, 1'b0);
      push_frame(32'h0000_8000, 8, 1'b1);
      frame_start(32'h0000_8000);
      finish_frame("frame_8000", 20);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/framebuffer_fetch.md
FRAMEBUFFER_FETCH -- requirements
Module: framebuffer_fetch

Interface
REQ-001 The block SHALL have the following parameters, one per line (name, default, meaning):
- FRAME_PIXELS, 384000, pixels per frame (800x480).
- BURST_LEN, 16, maximum memory read burst length in words.
- FIFO_DEPTH, 64, pixel FIFO entries; power of two and >= 2*BURST_LEN.

REQ-002 The block SHALL have the following ports, one per line (name, direction, width, meaning):
- in_clk, input, 1, sole clock.
- in_reset_n, input, 1, reset; asynchronous, active-low.
- in_next_frame, input, 1, high while the display is in its first blanking line.
- in_base_addr, input, 32, framebuffer word address, sampled at frame start.
- out_mem_address, output, 32, burst start word address.
- out_mem_read, output, 1, read request.
- out_mem_burstcount, output, 5, words in this burst.
- in_mem_waitrequest, input, 1, memory stall.
- in_mem_readdata, input, 32, read word; pixel in bits [23:0].
- in_mem_readdatavalid, input, 1, one returned word this cycle.
- out_pixel_data, output, 24, FIFO head pixel.
- out_pixel_valid, output, 1, head valid.
- in_pixel_ready, input, 1, consumer accepts the pixel.
- out_underflow, output, 1, sticky starvation flag for the current frame.
- out_busy, output, 1, high when the FSM is not IDLE.

Function
REQ-003 The block SHALL implement FSM states IDLE, FLUSH, FETCH and DONE.
REQ-004 The block SHALL treat a 0->1 transition of in_next_frame, sampled via one internal register, as frame start.
REQ-005 At frame start the block SHALL do all of the following: latch in_base_addr into the address counter, load remaining=FRAME_PIXELS (19 bits), clear the FIFO, and clear out_underflow.
- If outstanding words are 0, the FSM SHALL go to FETCH; otherwise it SHALL go to FLUSH.
- Frame start SHALL take effect from any state.
REQ-006 In FLUSH, returned words SHALL be discarded, and the FSM SHALL move to FETCH in the cycle after outstanding reaches 0.
REQ-007 In FETCH, with no request pending, the block SHALL issue a request when all of the following hold:
- remaining != 0;
- FIFO free entries minus outstanding >= burst, where burst = min(BURST_LEN, remaining).
REQ-008 The request SHALL assert out_mem_read with stable out_mem_address and out_mem_burstcount until a cycle with in_mem_waitrequest=0.
- On that cycle: address += burst, remaining -= burst, outstanding += burst.
REQ-009 Each in_mem_readdatavalid cycle SHALL decrement outstanding by 1; outside FLUSH it SHALL also push readdata[23:0] into the FIFO.
- An acceptance and a return in the same cycle SHALL net correctly.
- The FIFO SHALL never overflow; credit accounting guarantees this.
REQ-010 The FSM SHALL move from FETCH to DONE when remaining=0 and outstanding=0; DONE SHALL hold until the next frame start.
REQ-011 out_pixel_valid SHALL be FIFO non-empty AND in_next_frame=0, so prefetched pixels are held while the display drains its pipeline.
REQ-012 A pop SHALL occur on out_pixel_valid && in_pixel_ready.
- A push and a pop in the same cycle SHALL leave the FIFO count unchanged.
- Data SHALL be first-word fall-through, with zero latency from push to visible head when the FIFO is empty.
REQ-013 out_underflow SHALL set when, in FETCH or DONE, in_next_frame=0, in_pixel_ready=1 and the FIFO is empty, and fewer than FRAME_PIXELS pixels have been popped this frame.
REQ-014 Address arithmetic SHALL wrap modulo 2^32.

Reset
REQ-015 While in_reset_n=0 the block SHALL force:
- state=IDLE; out_mem_read=0; out_pixel_valid=0; out_underflow=0; out_busy=0;
- FIFO empty; remaining=0; outstanding=0;
- out_mem_address=0; out_mem_burstcount=0; edge register=0.
REQ-016 After reset release, the block SHALL stay in IDLE until the first frame start; memory returns arriving in IDLE SHALL be ignored and SHALL NOT underflow the outstanding counter.

Verification
REQ-017 Base 0x1000, zero-latency memory, frame start -> first burst at 0x1000 with count 16; the FIFO fills to 64; out_pixel_valid=0 until in_next_frame falls.
REQ-018 FRAME_PIXELS=40, BURST_LEN=16 -> bursts of 16, 16 and 8 at base, +16 and +32, then DONE, with exactly 40 pixels popped in order.
REQ-019 waitrequest held for 5 cycles on the first burst -> address and burstcount stable throughout, a single acceptance, remaining decremented once.
REQ-020 Frame start with 12 words outstanding -> FLUSH discards 12 returns, then FETCH restarts at the new base, and the FIFO holds no stale data.
REQ-021 Memory stalled and consumer ready with in_next_frame=0 and the FIFO empty -> out_underflow=1 and stays 1 until the next frame start clears it.
REQ-022 Reset asserted mid-burst with 8 outstanding -> all outputs go to reset values immediately, and later stray returns leave outstanding at 0.
